// File: rtl/param_frame_loader.sv
// Byte-stream loader for the perceptron parameter store: hunts for a sync byte, then
// writes a fixed-length payload. Define PARAM_CHECKSUM_EN to require a trailing checksum byte.
module param_frame_loader #(
   parameter int unsigned NUM_PARAMS = 24,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int unsigned ADDR_W     = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        data_in,
   input  logic              data_valid,
   input  logic              start,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_PARAMS - 1);

`ifdef PARAM_CHECKSUM_EN
   typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;
`else
   typedef enum logic [1:0] {StIdle, StLoad} state_e;
`endif

   state_e state_q, state_d;

   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef PARAM_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic [7:0]        sum_total;
   logic              error_q, error_d;

   assign sum_total = sum_q + data_in;
`endif

   // start wins over data_valid: a byte presented with start is discarded.
   logic accept;
   assign accept = data_valid & ~start;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && data_in == SYNC_BYTE) state_d = StLoad;
         end
         StLoad: begin
`ifdef PARAM_CHECKSUM_EN
            if (accept && idx_q == LastIdx) state_d = StCheck;
`else
            if (accept && idx_q == LastIdx) state_d = StIdle;
`endif
         end
`ifdef PARAM_CHECKSUM_EN
         StCheck: begin
            if (accept) state_d = StIdle;
         end
`endif
         default: state_d = StIdle;
      endcase
      if (start) state_d = StIdle;
   end

   always_comb begin
      idx_d     = idx_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = done_q;
`ifdef PARAM_CHECKSUM_EN
      sum_d     = sum_q;
      error_d   = error_q;
`endif
      if (start) begin
         idx_d  = '0;
         done_d = 1'b0;
`ifdef PARAM_CHECKSUM_EN
         sum_d   = '0;
         error_d = 1'b0;
`endif
      end else if (data_valid) begin
         unique case (state_q)
            StIdle: begin
               if (data_in == SYNC_BYTE) begin
                  idx_d  = '0;
                  done_d = 1'b0;
`ifdef PARAM_CHECKSUM_EN
                  sum_d   = '0;
                  error_d = 1'b0;
`endif
               end
            end
            StLoad: begin
               wr_en_d   = 1'b1;
               wr_addr_d = idx_q;
               wr_data_d = data_in;
`ifdef PARAM_CHECKSUM_EN
               sum_d     = sum_total;
`endif
               if (idx_q == LastIdx) begin
                  idx_d = '0;
`ifndef PARAM_CHECKSUM_EN
                  done_d = 1'b1;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
`ifdef PARAM_CHECKSUM_EN
            StCheck: begin
               done_d  = (sum_total == 8'h00);
               error_d = (sum_total != 8'h00);
            end
`endif
            default: ;
         endcase
      end
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
         sum_q     <= '0;
         error_q   <= 1'b0;
`endif
      end else begin
         idx_q     <= idx_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef PARAM_CHECKSUM_EN
         sum_q     <= sum_d;
         error_q   <= error_d;
`endif
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;
`ifdef PARAM_CHECKSUM_EN
   assign error   = error_q;
`else
   assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_param_frame_loader.sv
// Directed bench for param_frame_loader; builds with or without PARAM_CHECKSUM_EN.
module tb_param_frame_loader;

   localparam int unsigned ADDR_W = 5;

   logic              clk;
   logic              rstn;
   logic [7:0]        data_in;
   logic              data_valid;
   logic              start;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic              error;

   int n_cmp = 0;
   int n_err = 0;

   param_frame_loader #(
      .NUM_PARAMS (24),
      .SYNC_BYTE  (8'hA5),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .data_in    (data_in),
      .data_valid (data_valid),
      .start      (start),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; the byte is taken at the next rising edge.
   task automatic push(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".wr_en"}, wr_en, 0);
      check({tag, ".wr_addr"}, wr_addr, 0);
      check({tag, ".wr_data"}, wr_data, 0);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".error"}, error, 0);
   endtask

   // Full frame: sync, 24 payload bytes (i+1, optional 0xA5 at idx 3), checksum if enabled.
   task automatic run_frame(input bit gaps, input bit with_a5, input logic [7:0] cks);
      logic [7:0] p;
      logic [7:0] sum;
      bit         ok;
      sum = 8'h00;
      push(8'hA5);
      check("sync.busy", busy, 1);
      check("sync.wr_en", wr_en, 0);
      if (gaps) begin
         @(negedge clk);
         check("gap.busy", busy, 1);
      end
      for (int i = 0; i < 24; i++) begin
         p = (with_a5 && i == 3) ? 8'hA5 : 8'(i + 1);
         sum = sum + p;
         push(p);
         check("wr_en", wr_en, 1);
         check("wr_addr", wr_addr, i);
         check("wr_data", wr_data, p);
         if (gaps) begin
            @(negedge clk);
            check("gap.wr_en", wr_en, 0);
            check("gap.wr_addr_hold", wr_addr, i);
         end
         if (i < 23) check("load.busy", busy, 1);
      end
`ifdef PARAM_CHECKSUM_EN
      check("pre_cks.busy", busy, 1);
      check("pre_cks.done", done, 0);
      push(cks);
      check("cks.wr_en", wr_en, 0);
      ok = ((sum + cks) == 8'h00);
`else
      ok = 1'b1;
`endif
      check("end.busy", busy, 0);
      check("end.done", done, ok);
      check("end.error", error, !ok);
   endtask

   initial begin
      rstn       = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;
      start      = 1'b0;
      #3 rstn = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Non-sync bytes in IDLE are ignored.
      push(8'h00);
      push(8'hFF);
      push(8'h5A);
      check("idle.wr_en", wr_en, 0);
      check("idle.busy", busy, 0);
      check("idle.done", done, 0);

      // Good frame (sum 0x2C + 0xD4 = 0x100), then bad checksum back-to-back.
      run_frame(1'b0, 1'b0, 8'hD4);
      run_frame(1'b0, 1'b0, 8'hD5);

      // A new sync clears flags; abort with start at idx 10.
      push(8'hA5);
      check("resync.error", error, 0);
      check("resync.done", done, 0);
      check("resync.busy", busy, 1);
      for (int i = 0; i < 10; i++) push(8'(i + 1));
      check("pre_abort.wr_addr", wr_addr, 9);
      data_in    = 8'h0B;
      data_valid = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      data_valid = 1'b0;
      check("abort.wr_en", wr_en, 0);
      check("abort.busy", busy, 0);
      check("abort.done", done, 0);
      check("abort.error", error, 0);

      // Reload from addr 0, with gaps, then payload carrying 0xA5 (sum 0xCD, cks 0x33).
      run_frame(1'b1, 1'b0, 8'hD4);
      run_frame(1'b0, 1'b1, 8'h33);

      // Asynchronous reset mid-frame at idx 15.
      push(8'hA5);
      for (int i = 0; i < 15; i++) push(8'(i + 1));
      check("pre_rst.wr_en", wr_en, 1);
      check("pre_rst.busy", busy, 1);
      #2 rstn = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst.busy", busy, 0);

      run_frame(1'b0, 1'b0, 8'hD4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
